// File: rtl/alu_sequencer.sv
// alu_sequencer: operand reads -> ALU calc -> write-back over held request/ack handshakes; min latency 2*N_OPERANDS+3 cycles, each request waits for its ack.
// ALU_SEQ_TIMEOUT_EN adds a per-handshake timeout that aborts through ERR and sets the sticky error flag.
module alu_sequencer #(
    parameter int N_OPERANDS     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       read_Instr,
    output logic       init_Memory,
    output logic [1:0] op_idx,
    input  logic       doneMemory,
    output logic       initCalcule,
    input  logic       doneCalcule,
    output logic       initrd,
    input  logic       doneresult,
    output logic       busy,
    output logic       done,
    output logic       error
);

    if (N_OPERANDS < 1 || N_OPERANDS > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
        CNT_W < 1 || 64'(TIMEOUT_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_params
        $error("alu_sequencer: illegal parameter combination");
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, MEM, CALC, WB, FIN, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, MEM, CALC, WB, FIN} state_t;
`endif

    localparam logic [1:0] LAST_OP = 2'(N_OPERANDS - 1);

    state_t     state_q, state_d;
    logic [1:0] op_idx_q, op_idx_d;
    logic       init_mem_q, init_mem_d;
    logic       init_calc_q, init_calc_d;
    logic       init_rd_q, init_rd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic             error_q, error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_wait;

    // a request is outstanding and its acknowledge did not arrive this cycle
    assign req_wait = (init_mem_q & ~doneMemory) | (init_calc_q & ~doneCalcule) |
                      (init_rd_q & ~doneresult);
`endif

    always_comb begin
        state_d     = state_q;
        op_idx_d    = op_idx_q;
        init_mem_d  = 1'b0;
        init_calc_d = 1'b0;
        init_rd_d   = 1'b0;
        done_d      = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        error_d     = error_q;
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (read_Instr) begin
                    state_d    = MEM;
                    op_idx_d   = '0;
                    init_mem_d = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                end
            end
            MEM: begin
                if (init_mem_q && doneMemory) begin
                    if (op_idx_q == LAST_OP) begin
                        state_d     = CALC;
                        init_calc_d = 1'b1;
                    end else begin
                        // request drops for one cycle between operands
                        op_idx_d = op_idx_q + 2'd1;
                    end
                end else begin
                    init_mem_d = 1'b1;
                end
            end
            CALC: begin
                if (doneCalcule) begin
                    state_d   = WB;
                    init_rd_d = 1'b1;
                end else begin
                    init_calc_d = 1'b1;
                end
            end
            WB: begin
                if (doneresult) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    init_rd_d = 1'b1;
                end
            end
            FIN: begin
                state_d  = IDLE;
                op_idx_d = '0;
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            ERR: begin
                state_d  = IDLE;
                op_idx_d = '0;
            end
`endif
            default: begin
                state_d  = IDLE;
                op_idx_d = '0;
            end
        endcase
`ifdef ALU_SEQ_TIMEOUT_EN
        if (req_wait) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ERR;
                init_mem_d  = 1'b0;
                init_calc_d = 1'b0;
                init_rd_d   = 1'b0;
                error_d     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_idx_q    <= '0;
            init_mem_q  <= 1'b0;
            init_calc_q <= 1'b0;
            init_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            error_q     <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_idx_q    <= op_idx_d;
            init_mem_q  <= init_mem_d;
            init_calc_q <= init_calc_d;
            init_rd_q   <= init_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            error_q     <= error_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign init_Memory = init_mem_q;
    assign initCalcule = init_calc_q;
    assign initrd      = init_rd_q;
    assign op_idx      = op_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    assign error       = error_q;
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: three instances (1, 2, 4 operands) checked cycle by cycle against a transaction-level timeline model.
// Exercises ALU_SEQ_TIMEOUT_EN behaviour too when the macro is defined for the build.
module tb_alu_sequencer;

    localparam int NOPS [3] = '{1, 2, 4};
`ifdef ALU_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] rd_i = '0, dm_i = '0, dc_i = '0, dr_i = '0;
    logic [2:0] imem, icalc, ird, bsy, dn, er;
    logic [1:0] opx [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_sequencer #(.N_OPERANDS(NOPS[g]), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut (
            .clk(clk), .reset_n(reset_n), .read_Instr(rd_i[g]),
            .init_Memory(imem[g]), .op_idx(opx[g]), .doneMemory(dm_i[g]),
            .initCalcule(icalc[g]), .doneCalcule(dc_i[g]),
            .initrd(ird[g]), .doneresult(dr_i[g]),
            .busy(bsy[g]), .done(dn[g]), .error(er[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle of the expected timeline: inputs to apply and outputs to see
    // packed as {init_Memory, initCalcule, initrd, op_idx[1:0], busy, done, error}.
    typedef struct packed {
        logic       rd;
        logic       dm;
        logic       dc;
        logic       dr;
        logic [7:0] exp;
    } cyc_t;

    cyc_t tr[$];
    int   dly_m [4];
    logic merr [3] = '{1'b0, 1'b0, 1'b0};
    int   lat, n_req, last_op, run, run_exp = 0;

    function automatic logic [7:0] ov(input logic m, input logic c, input logic r, input int op,
                                      input logic b, input logic d, input logic e);
        logic [1:0] o;
        o = op[1:0];
        return {m, c, r, o, b, d, e};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push(input logic rd, input logic dm, input logic dc, input logic dr, input logic [7:0] e);
        cyc_t c;
        c.rd = rd; c.dm = dm; c.dc = dc; c.dr = dr; c.exp = e;
        tr.push_back(c);
    endtask

    task automatic idle_cyc(input int u, input bit quiet);
        if (quiet) push(1'b0, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, merr[u]));
        else       push(1'b0, rb(), rb(), rb(), ov(0, 0, 0, 0, 0, 0, merr[u]));
    endtask

    // Appends one instruction: the read_Instr cycle through FIN (or ERR on a stalled write-back).
    // Acks not belonging to the current wait state carry random noise that must be ignored.
    task automatic build(input int u, input int dc, input int dr, input bit hold, input bit stall_wb);
        int n;
        n = NOPS[u];
        push(1'b1, rb(), rb(), rb(), ov(0, 0, 0, 0, 0, 0, merr[u]));
        if (TO_EN) merr[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w <= dly_m[k]; w++)
                push(rb(), (w == dly_m[k]), rb(), rb(), ov(1, 0, 0, k, 1, 0, 0));
            if (k < n - 1) push(rb(), 1'b0, rb(), rb(), ov(0, 0, 0, k + 1, 1, 0, 0));
        end
        for (int w = 0; w <= dc; w++)
            push(rb(), rb(), (w == dc), rb(), ov(0, 1, 0, n - 1, 1, 0, 0));
        if (stall_wb) begin
            for (int w = 0; w < 8; w++) push(rb(), rb(), rb(), 1'b0, ov(0, 0, 1, n - 1, 1, 0, 0));
            push(rb(), rb(), rb(), rb(), ov(0, 0, 0, n - 1, 1, 0, 1));
            merr[u] = 1'b1;
        end else begin
            for (int w = 0; w <= dr; w++)
                push(rb(), rb(), rb(), (w == dr), ov(0, 0, 1, n - 1, 1, 0, 0));
            push(hold ? 1'b1 : rb(), rb(), rb(), rb(), ov(0, 0, 0, n - 1, 1, 1, 0));
        end
    endtask

    // Plays the timeline on instance u; stops before driving entry abort_at.
    task automatic exec(input int u, input int abort_at);
        logic [7:0] got;
        logic       prev_m;
        prev_m = 1'b0;
        lat = -1; n_req = 0; last_op = -1; run = 0;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            got = {imem[u], icalc[u], ird[u], opx[u], bsy[u], dn[u], er[u]};
            chk($sformatf("u%0d cycle %0d", u, i), got, tr[i].exp);
            if (got[7]) begin
                if (!prev_m) n_req++;
                last_op = int'(got[4:3]);
                run++;
            end else if (prev_m) begin
                if (run_exp > 0) chk($sformatf("u%0d mem_hold", u), run, run_exp);
                run = 0;
            end
            prev_m = got[7];
            if (got[1] && lat < 0) lat = i + 1;
            if (i == abort_at) break;
            rd_i[u] = tr[i].rd; dm_i[u] = tr[i].dm; dc_i[u] = tr[i].dc; dr_i[u] = tr[i].dr;
        end
    endtask

    task automatic set_dly(input int d);
        for (int k = 0; k < 4; k++) dly_m[k] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset with random inputs: every output low
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            rd_i = 3'($urandom); dm_i = 3'($urandom); dc_i = 3'($urandom); dr_i = 3'($urandom);
            @(negedge clk);
            for (int u = 0; u < 3; u++)
                chk($sformatf("reset u%0d", u), {imem[u], icalc[u], ird[u], opx[u], bsy[u], dn[u], er[u]}, 0);
        end
        rd_i = '0; dm_i = '0; dc_i = '0; dr_i = '0;
        reset_n = 1'b1;

        // zero-wait acks: latency, request count, last operand index
        for (int u = 0; u < 3; u++) begin
            set_dly(0);
            tr.delete();
            build(u, 0, 0, 1'b0, 1'b0);
            idle_cyc(u, 1'b1);
            exec(u, -1);
            chk($sformatf("u%0d latency", u), lat, 2 * NOPS[u] + 3);
            chk($sformatf("u%0d n_req", u), n_req, NOPS[u]);
            chk($sformatf("u%0d last_op", u), last_op, NOPS[u] - 1);
        end

        // memory ack 5 cycles late: each request held 6 cycles
        set_dly(5);
        run_exp = 6;
        tr.delete();
        build(1, 0, 0, 1'b0, 1'b0);
        idle_cyc(1, 1'b1);
        exec(1, -1);
        chk("u1 delayed n_req", n_req, 2);
        run_exp = 0;

        // read_Instr held through FIN: second instruction starts only from IDLE
        set_dly(1);
        tr.delete();
        build(1, 1, 0, 1'b1, 1'b0);
        build(1, 0, 2, 1'b1, 1'b0);
        idle_cyc(1, 1'b1);
        exec(1, -1);
        chk("u1 back_to_back n_req", n_req, 4);

        // reset during CALC aborts; later acks produce nothing
        set_dly(0);
        tr.delete();
        build(1, 0, 0, 1'b0, 1'b0);
        exec(1, 4);
        reset_n = 1'b0;
        rd_i[1] = 1'b0; dm_i[1] = 1'b1; dc_i[1] = 1'b1; dr_i[1] = 1'b1;
        for (int u = 0; u < 3; u++) merr[u] = 1'b0;
        @(negedge clk);
        chk("u1 reset_in_calc", {imem[1], icalc[1], ird[1], opx[1], bsy[1], dn[1], er[1]}, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("u1 ack_after_reset", {imem[1], icalc[1], ird[1], opx[1], bsy[1], dn[1], er[1]}, 0);
        end
        dm_i[1] = 1'b0; dc_i[1] = 1'b0; dr_i[1] = 1'b0;

`ifdef ALU_SEQ_TIMEOUT_EN
        // write-back never acknowledged: ERR, sticky error, cleared by next instruction
        set_dly(0);
        tr.delete();
        build(1, 0, 0, 1'b0, 1'b1);
        idle_cyc(1, 1'b0);
        idle_cyc(1, 1'b0);
        build(1, 0, 0, 1'b0, 1'b0);
        idle_cyc(1, 1'b1);
        exec(1, -1);
        chk("u1 timeout_then_ok done_count", (lat > 0), 1);
`endif

        // randomized instructions across all three instances
        for (int it = 0; it < 30; it++) begin
            int u;
            u = $urandom_range(2, 0);
            for (int k = 0; k < 4; k++) dly_m[k] = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(6, 0);
            tr.delete();
            build(u, $urandom_range(6, 0), $urandom_range(6, 0), rb(), 1'b0);
            for (int g = $urandom_range(2, 0); g > 0; g--) idle_cyc(u, 1'b0);
            idle_cyc(u, 1'b1);
            exec(u, -1);
            chk($sformatf("rand u%0d n_req", u), n_req, NOPS[u]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter N_OPERANDS, default 2, number of operand memory reads per instruction; legal range 1..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum wait cycles per handshake; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16, width of the timeout counter; SHALL hold TIMEOUT_CYCLES.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 Port read_Instr  input  1  instruction-start request, sampled in IDLE only.
REQ-007 Port init_Memory  output  1  operand-read request to memory, held until acknowledged.
REQ-008 Port op_idx  output  2  index of the operand being read, 0..N_OPERANDS-1.
REQ-009 Port doneMemory  input  1  memory acknowledge for the current operand.
REQ-010 Port initCalcule  output  1  calculation request to the ALU datapath, held until acknowledged.
REQ-011 Port doneCalcule  input  1  ALU acknowledge.
REQ-012 Port initrd  output  1  result write-back request, held until acknowledged.
REQ-013 Port doneresult  input  1  write-back acknowledge.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port done  output  1  one-cycle pulse on successful instruction completion.
REQ-016 Port error  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, MEM, CALC, WB, FIN, ERR; all outputs registered.
REQ-018 IDLE: read_Instr=1 at edge -> MEM at that edge, op_idx=0, init_Memory=1 from the next cycle.
REQ-019 MEM: init_Memory=1; doneMemory=1 sampled with op_idx<N_OPERANDS-1 -> op_idx+1, init_Memory drops for exactly one cycle, then reasserts.
REQ-020 MEM: doneMemory=1 sampled with op_idx=N_OPERANDS-1 -> CALC; init_Memory=0, initCalcule=1 from the next cycle.
REQ-021 CALC: doneCalcule=1 sampled -> WB; initCalcule=0, initrd=1 from the next cycle.
REQ-022 WB: doneresult=1 sampled -> FIN; initrd=0.
REQ-023 FIN: done=1 for exactly one cycle, then IDLE; op_idx returns to 0.
REQ-024 Acknowledge inputs sampled outside their own wait state SHALL be ignored.
REQ-025 read_Instr while busy SHALL be ignored; no queuing.
REQ-026 Zero-wait acknowledge (done high on first request cycle) SHALL be accepted; minimum latency read_Instr to done = 2*N_OPERANDS+3 cycles.
REQ-027 At most one of init_Memory, initCalcule, initrd SHALL be high in any cycle.

Reset
REQ-028 reset_n=0 at an edge SHALL force IDLE, op_idx=0, init_Memory=initCalcule=initrd=busy=done=error=0, timeout counter=0.
REQ-029 Reset mid-operation SHALL abort the instruction with no done pulse; pending acknowledges after release are ignored.

Configuration
REQ-030 Macro ALU_SEQ_TIMEOUT_EN defined: counter clears on each state entry, increments each cycle in MEM/CALC/WB; reaching TIMEOUT_CYCLES without acknowledge -> ERR.
REQ-031 ERR: all requests 0, busy=1 for one cycle, error=1 set; then IDLE; error clears when the next read_Instr is accepted.
REQ-032 Macro undefined: no counter, no ERR state, error tied 0; handshakes wait indefinitely.

Verification
REQ-033 N_OPERANDS=2, all acks zero-wait: read_Instr pulse -> op_idx 0 then 1, done pulse 7 cycles after read_Instr.
REQ-034 doneMemory delayed 5 cycles per operand -> init_Memory held high 6 cycles per operand, one-cycle gap between operands.
REQ-035 read_Instr held high through a full instruction -> second instruction starts only after FIN returns to IDLE.
REQ-036 reset_n=0 during CALC -> next cycle all outputs 0, IDLE; later doneCalcule=1 produces no response.
REQ-037 ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, doneresult never asserted -> initrd drops after 8 cycles, error=1, no done; next read_Instr clears error.
REQ-038 N_OPERANDS=1 and N_OPERANDS=4 -> exactly 1 and 4 init_Memory requests, op_idx final value 0 and 3.
